// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: S1 registers sprite hits, S2 registers RGB; per-frame plane collision flag.
// Optional game-over blink (red/black, BLINK_FRAMES per half-period) under macro COMPOSITOR_GAMEOVER_BLINK_EN.
module sprite_compositor #(
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned N_OBST       = 2,
  parameter int unsigned PLANE_X      = 100,
  parameter int unsigned PLANE_SIZE   = 16,
  parameter int unsigned OBST_W       = 30,
  parameter int unsigned LAVA_SIZE    = 16,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bright,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 frame_start,
  input  logic [9:0]           plane_y,
  input  logic [10*N_OBST-1:0] mountain_x,
  input  logic [10*N_OBST-1:0] mountain_y,
  input  logic [9:0]           lava_x,
  input  logic [9:0]           lava_y,
  input  logic                 game_over,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 collision,
  output logic                 coll_valid
);

  localparam logic [10:0] PX_LO = 11'(PLANE_X);
  localparam logic [10:0] PX_HI = 11'(PLANE_X + PLANE_SIZE);
  localparam logic [10:0] P_SZ  = 11'(PLANE_SIZE);
  localparam logic [10:0] O_W   = 11'(OBST_W);
  localparam logic [10:0] L_SZ  = 11'(LAVA_SIZE);

  logic [10:0] xe, ye;
  logic        plane_c, mtn_c, lava_c;

  // Bounds are widened to 11 bits so sprites near column/row 1023 do not wrap.
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  always_comb begin
    plane_c = (xe >= PX_LO) && (xe <= PX_HI) &&
              (ye >= {1'b0, plane_y}) && (ye <= {1'b0, plane_y} + P_SZ);
    lava_c  = (xe >= {1'b0, lava_x}) && (xe <= {1'b0, lava_x} + L_SZ) &&
              (ye >= {1'b0, lava_y}) && (ye <= {1'b0, lava_y} + L_SZ);
    mtn_c   = 1'b0;
    for (int i = 0; i < int'(N_OBST); i++) begin
      if ((xe >= {1'b0, mountain_x[10*i +: 10]}) &&
          (xe <= {1'b0, mountain_x[10*i +: 10]} + O_W) &&
          (y >= mountain_y[10*i +: 10]))
        mtn_c = 1'b1;
    end
  end

  logic s1_plane, s1_mtn, s1_lava, s1_bright, s1_go, s1_fs;
  logic acc, overlap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_plane  <= 1'b0;
      s1_mtn    <= 1'b0;
      s1_lava   <= 1'b0;
      s1_bright <= 1'b0;
      s1_go     <= 1'b0;
      s1_fs     <= 1'b0;
    end else begin
      s1_plane  <= plane_c;
      s1_mtn    <= mtn_c;
      s1_lava   <= lava_c;
      s1_bright <= bright;
      s1_go     <= game_over;
      s1_fs     <= frame_start;
    end
  end

  // frame_start travels with its pixel through S1, so that pixel closes the old frame.
  assign overlap = s1_bright & s1_plane & (s1_mtn | s1_lava);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= 1'b0;
      collision  <= 1'b0;
      coll_valid <= 1'b0;
    end else begin
      coll_valid <= s1_fs;
      if (s1_fs) begin
        collision <= acc | overlap;
        acc       <= 1'b0;
      end else begin
        acc       <= acc | overlap;
      end
    end
  end

  logic go_red;

`ifdef COMPOSITOR_GAMEOVER_BLINK_EN
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (s1_fs) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + CW'(1);
      end
    end
  end

  assign go_red = s1_bright & blink_phase;
`else
  logic [31:0] blink_frames_unused;
  assign blink_frames_unused = 32'(BLINK_FRAMES);
  assign go_red = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      if (s1_go) begin
        red <= {COLOR_W{go_red}};
      end else if (s1_bright) begin
        if (s1_plane)     blue  <= '1;
        else if (s1_mtn)  green <= '1;
        else if (s1_lava) red   <= '1;
      end
    end
  end

endmodule
